// File: rtl/sram_arbiter.sv
// Two-requester sequencer that splits 32-bit word transactions onto a 16-bit SRAM port, low half first.
// Define SRAM_ARB_RR_EN for round-robin arbitration; the default is fixed instruction priority.
module sram_arbiter #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_req_i,
    input  logic [31:0] inst_add_i,
    output logic        inst_ack_o,
    output logic [31:0] inst_dat_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [31:0] data_add_i,
    input  logic [31:0] data_dat_i,
    output logic        data_ack_o,
    output logic [31:0] data_dat_o,
    output logic [31:0] sram_address_o,
    output logic        sram_rden_o,
    output logic        sram_wren_o,
    output logic [15:0] sram_dat_o,
    input  logic [15:0] sram_dat_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_LO_W,
        S_HI,
        S_HI_W,
        S_ACK
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic        we_q, we_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] lo_q, lo_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        inst_ack_q, inst_ack_d;
    logic        data_ack_q, data_ack_d;
    logic [31:0] inst_dat_q, inst_dat_d;
    logic [31:0] data_dat_q, data_dat_d;
    logic [31:0] addr_q, addr_d;
    logic        rden_q, rden_d;
    logic        wren_q, wren_d;
    logic [15:0] sdat_q, sdat_d;
    logic        busy_q, busy_d;

    logic        grant_valid;
    owner_t      grant_owner;
    logic [31:0] rd_word;

`ifdef SRAM_ARB_RR_EN
    owner_t last_owner_q, last_owner_d;

    // On contention the requester that was not served last wins.
    always_comb begin
        grant_valid  = inst_req_i | data_req_i;
        last_owner_d = last_owner_q;
        if (inst_req_i && data_req_i) begin
            grant_owner = (last_owner_q == OWN_INST) ? OWN_DATA : OWN_INST;
        end else begin
            grant_owner = inst_req_i ? OWN_INST : OWN_DATA;
        end
        if (state_q == S_IDLE && grant_valid) begin
            last_owner_d = grant_owner;
        end
    end
`else
    always_comb begin
        grant_valid = inst_req_i | data_req_i;
        grant_owner = inst_req_i ? OWN_INST : OWN_DATA;
    end
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        rd_word = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    state_d = S_LO;
                    owner_d = grant_owner;
                    lo_d    = 16'h0;
                    if (grant_owner == OWN_INST) begin
                        we_d    = 1'b0;
                        base_d  = inst_add_i & WORD_MASK;
                        wdata_d = 32'h0;
                    end else begin
                        we_d    = data_we_i;
                        base_d  = data_add_i & WORD_MASK;
                        wdata_d = data_we_i ? data_dat_i : 32'h0;
                    end
                end
            end
            S_LO: begin
                state_d = we_q ? S_HI : S_LO_W;
                cnt_d   = WAIT_INIT;
            end
            S_LO_W: begin
                if (cnt_q == 3'd0) begin
                    lo_d    = sram_dat_i;
                    state_d = S_HI;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_HI: begin
                state_d = we_q ? S_ACK : S_HI_W;
                cnt_d   = WAIT_INIT;
            end
            S_HI_W: begin
                if (cnt_q == 3'd0) begin
                    rd_word = {sram_dat_i, lo_q};
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that they can be registered and still line up with it.
    always_comb begin
        rden_d     = 1'b0;
        wren_d     = 1'b0;
        addr_d     = 32'h0;
        sdat_d     = 16'h0;
        inst_ack_d = 1'b0;
        data_ack_d = 1'b0;
        inst_dat_d = 32'h0;
        data_dat_d = 32'h0;
        busy_d     = (state_d != S_IDLE);

        case (state_d)
            S_LO: begin
                rden_d = ~we_d;
                wren_d = we_d;
                addr_d = base_d;
                sdat_d = we_d ? wdata_d[15:0] : 16'h0;
            end
            S_HI: begin
                rden_d = ~we_d;
                wren_d = we_d;
                addr_d = base_d + 32'd2;
                sdat_d = we_d ? wdata_d[31:16] : 16'h0;
            end
            S_ACK: begin
                if (owner_d == OWN_INST) begin
                    inst_ack_d = 1'b1;
                    inst_dat_d = rd_word;
                end else begin
                    data_ack_d = 1'b1;
                    data_dat_d = rd_word;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; all next values come from the comb blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_INST;
            we_q       <= 1'b0;
            base_q     <= 32'h0;
            wdata_q    <= 32'h0;
            lo_q       <= 16'h0;
            cnt_q      <= 3'd0;
            inst_ack_q <= 1'b0;
            data_ack_q <= 1'b0;
            inst_dat_q <= 32'h0;
            data_dat_q <= 32'h0;
            addr_q     <= 32'h0;
            rden_q     <= 1'b0;
            wren_q     <= 1'b0;
            sdat_q     <= 16'h0;
            busy_q     <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            last_owner_q <= OWN_DATA;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            lo_q       <= lo_d;
            cnt_q      <= cnt_d;
            inst_ack_q <= inst_ack_d;
            data_ack_q <= data_ack_d;
            inst_dat_q <= inst_dat_d;
            data_dat_q <= data_dat_d;
            addr_q     <= addr_d;
            rden_q     <= rden_d;
            wren_q     <= wren_d;
            sdat_q     <= sdat_d;
            busy_q     <= busy_d;
`ifdef SRAM_ARB_RR_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    assign inst_ack_o     = inst_ack_q;
    assign inst_dat_o     = inst_dat_q;
    assign data_ack_o     = data_ack_q;
    assign data_dat_o     = data_dat_q;
    assign sram_address_o = addr_q;
    assign sram_rden_o    = rden_q;
    assign sram_wren_o    = wren_q;
    assign sram_dat_o     = sdat_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one instance at RD_LAT=1 and one at RD_LAT=3, each with a small SRAM model.
module tb_sram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        inst_req, data_req, data_we;
    logic [31:0] inst_add, data_add, data_wdat;
    logic        inst_ack, data_ack, s1_rden, s1_wren, busy1;
    logic [31:0] inst_dat, data_dat, s1_addr;
    logic [15:0] s1_dout, s1_din;

    logic        i3_req, d3_req, d3_we;
    logic [31:0] i3_add, d3_add, d3_wdat;
    logic        i3_ack, d3_ack, s3_rden, s3_wren, busy3;
    logic [31:0] i3_dat, d3_dat, s3_addr;
    logic [15:0] s3_dout, s3_din;

    int total = 0;
    int bad   = 0;

    sram_arbiter #(.RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_req_i(inst_req), .inst_add_i(inst_add), .inst_ack_o(inst_ack), .inst_dat_o(inst_dat),
        .data_req_i(data_req), .data_we_i(data_we), .data_add_i(data_add), .data_dat_i(data_wdat),
        .data_ack_o(data_ack), .data_dat_o(data_dat),
        .sram_address_o(s1_addr), .sram_rden_o(s1_rden), .sram_wren_o(s1_wren),
        .sram_dat_o(s1_dout), .sram_dat_i(s1_din), .busy_o(busy1)
    );

    sram_arbiter #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .inst_req_i(i3_req), .inst_add_i(i3_add), .inst_ack_o(i3_ack), .inst_dat_o(i3_dat),
        .data_req_i(d3_req), .data_we_i(d3_we), .data_add_i(d3_add), .data_dat_i(d3_wdat),
        .data_ack_o(d3_ack), .data_dat_o(d3_dat),
        .sram_address_o(s3_addr), .sram_rden_o(s3_rden), .sram_wren_o(s3_wren),
        .sram_dat_o(s3_dout), .sram_dat_i(s3_din), .busy_o(busy3)
    );

    function automatic logic [15:0] sram_val(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 16'hBEEF;
            32'h0000_0102: return 16'hDEAD;
            32'hFFFF_FFFC: return 16'h1111;
            32'hFFFF_FFFE: return 16'h2222;
            default:       return a[15:0] ^ 16'h5A5A;
        endcase
    endfunction

    // SRAM models: read data appears RD_LAT cycles after the rden cycle, junk otherwise.
    logic        v1 = 1'b0;
    logic [31:0] a1 = 32'h0;
    always @(posedge clk) begin
        v1 <= s1_rden;
        a1 <= s1_addr;
    end
    assign s1_din = v1 ? sram_val(a1) : 16'hFFFF;

    logic [2:0]  v3 = 3'b000;
    logic [31:0] a3 [3];
    always @(posedge clk) begin
        v3    <= {v3[1:0], s3_rden};
        a3[0] <= s3_addr;
        a3[1] <= a3[0];
        a3[2] <= a3[1];
    end
    assign s3_din = v3[2] ? sram_val(a3[2]) : 16'hFFFF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch read starting at the current cycle (T0); expects rden in T1/T3 and ack in T5.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp_word);
        inst_req = 1'b1;
        inst_add = a;
        for (int t = 0; t <= 5; t++) begin
            @(negedge clk);
            check($sformatf("fetch_rden_t%0d", t), 32'(s1_rden), 32'(t == 1 || t == 3));
            check($sformatf("fetch_addr_t%0d", t), s1_addr,
                  (t == 1) ? a : (t == 3) ? a + 32'd2 : 32'h0);
            check($sformatf("fetch_ack_t%0d", t), 32'(inst_ack), 32'(t == 5));
            check($sformatf("fetch_dat_t%0d", t), inst_dat, (t == 5) ? exp_word : 32'h0);
            check($sformatf("fetch_wren_t%0d", t), 32'(s1_wren), 32'h0);
            tick();
            if (t == 5) inst_req = 1'b0;
        end
        @(negedge clk);
        check("fetch_idle_after", 32'(busy1), 32'h0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        inst_req = 0; inst_add = 0; data_req = 0; data_we = 0; data_add = 0; data_wdat = 0;
        i3_req = 0; i3_add = 0; d3_req = 0; d3_we = 0; d3_add = 0; d3_wdat = 0;
        #2;
        check("rst_busy", 32'(busy1), 32'h0);
        check("rst_strobes", {30'h0, s1_rden, s1_wren}, 32'h0);
        check("rst_addr", s1_addr, 32'h0);
        check("rst_sdat", 32'(s1_dout), 32'h0);
        check("rst_acks", {30'h0, inst_ack, data_ack}, 32'h0);
        check("rst_dat", inst_dat | data_dat, 32'h0);
        check("rst_busy3", 32'(busy3), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        do_fetch(32'h0000_0100, 32'hDEAD_BEEF);

        // Data write at a misaligned address.
        data_req = 1'b1; data_we = 1'b1; data_add = 32'h0000_0203; data_wdat = 32'h1234_5678;
        for (int t = 0; t <= 4; t++) begin
            @(negedge clk);
            check($sformatf("wr_wren_t%0d", t), 32'(s1_wren), 32'(t == 1 || t == 2));
            check($sformatf("wr_rden_t%0d", t), 32'(s1_rden), 32'h0);
            check($sformatf("wr_addr_t%0d", t), s1_addr,
                  (t == 1) ? 32'h200 : (t == 2) ? 32'h202 : 32'h0);
            check($sformatf("wr_sdat_t%0d", t), 32'(s1_dout),
                  (t == 1) ? 32'h5678 : (t == 2) ? 32'h1234 : 32'h0);
            check($sformatf("wr_ack_t%0d", t), 32'(data_ack), 32'(t == 3));
            check($sformatf("wr_inst_ack_t%0d", t), 32'(inst_ack), 32'h0);
            check($sformatf("wr_dat_t%0d", t), data_dat, 32'h0);
            tick();
            if (t == 3) begin data_req = 1'b0; data_we = 1'b0; end
        end

        // Contention: instruction read wins, data write follows once inst drops req.
        inst_req = 1'b1; inst_add = 32'h0000_0100;
        data_req = 1'b1; data_we = 1'b1; data_add = 32'h0000_0300; data_wdat = 32'hCAFE_F00D;
        for (int t = 0; t <= 10; t++) begin
            @(negedge clk);
            check($sformatf("arb_inst_ack_t%0d", t), 32'(inst_ack), 32'(t == 5));
            check($sformatf("arb_data_ack_t%0d", t), 32'(data_ack), 32'(t == 9));
            check($sformatf("arb_busy_t%0d", t), 32'(busy1),
                  32'((t >= 1 && t <= 5) || (t >= 7 && t <= 9)));
            check($sformatf("arb_wren_t%0d", t), 32'(s1_wren), 32'(t == 7 || t == 8));
            check($sformatf("arb_rden_t%0d", t), 32'(s1_rden), 32'(t == 1 || t == 3));
            if (t == 5) check("arb_inst_dat", inst_dat, 32'hDEAD_BEEF);
            if (t == 8) check("arb_hi_sdat", 32'(s1_dout), 32'hCAFE);
            tick();
            if (t == 5) inst_req = 1'b0;
            if (t == 9) begin data_req = 1'b0; data_we = 1'b0; end
        end

        // RD_LAT=3 data read across the top of the address space.
        d3_req = 1'b1; d3_add = 32'hFFFF_FFFC;
        for (int t = 0; t <= 10; t++) begin
            @(negedge clk);
            check($sformatf("lat3_rden_t%0d", t), 32'(s3_rden), 32'(t == 1 || t == 5));
            check($sformatf("lat3_addr_t%0d", t), s3_addr,
                  (t == 1) ? 32'hFFFF_FFFC : (t == 5) ? 32'hFFFF_FFFE : 32'h0);
            check($sformatf("lat3_ack_t%0d", t), 32'(d3_ack), 32'(t == 9));
            check($sformatf("lat3_dat_t%0d", t), d3_dat, (t == 9) ? 32'h2222_1111 : 32'h0);
            check($sformatf("lat3_busy_t%0d", t), 32'(busy3), 32'(t >= 1 && t <= 9));
            tick();
            if (t == 9) d3_req = 1'b0;
        end

        // Requester drops req right after grant; bits [1:0]=10 must be ignored.
        data_req = 1'b1; data_we = 1'b0; data_add = 32'h0000_0102;
        for (int t = 0; t <= 9; t++) begin
            @(negedge clk);
            check($sformatf("drop_ack_t%0d", t), 32'(data_ack), 32'(t == 5));
            check($sformatf("drop_busy_t%0d", t), 32'(busy1), 32'(t >= 1 && t <= 5));
            check($sformatf("drop_rden_t%0d", t), 32'(s1_rden), 32'(t == 1 || t == 3));
            if (t == 1) check("drop_lo_addr", s1_addr, 32'h100);
            if (t == 5) check("drop_dat", data_dat, 32'hDEAD_BEEF);
            tick();
            if (t == 0) data_req = 1'b0;
        end

        // Reset asserted while the fetch waits on low-half read data.
        inst_req = 1'b1; inst_add = 32'h0000_0104;
        tick();
        @(negedge clk);
        check("abort_lo_addr", s1_addr, 32'h104);
        tick();
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy1), 32'h0);
        check("abort_strobes", {30'h0, s1_rden, s1_wren}, 32'h0);
        check("abort_addr", s1_addr, 32'h0);
        check("abort_acks", {30'h0, inst_ack, data_ack}, 32'h0);
        inst_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            check($sformatf("abort_noack_t%0d", t), 32'(inst_ack), 32'h0);
            check($sformatf("abort_idle_t%0d", t), 32'(busy1), 32'h0);
            tick();
        end
        do_fetch(32'h0000_0100, 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
